// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared light codes and request FSM states for the highway/farm controller pair
package tlc_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVING = 2'd2
  } req_state_e;

  // True only for the three one-hot codes the controller may drive.
  function automatic logic light_legal(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YEL) || (code == LIGHT_GRN);
  endfunction

endpackage

// File: rtl/tlc_sensor_debounce.sv
// rtl/tlc_sensor_debounce.sv - loop detector synchronizer, debouncer and arrival pulse
module tlc_sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic arrival_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          arrival_q, arrival_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples; flip the level on the last one and flag a rising flip.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    arrival_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d     = '0;
      level_d   = sync2_q;
      arrival_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Two-flop synchronizer plus debounce state; the arrival pulse is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      arrival_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      arrival_q <= arrival_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arrival_o = arrival_q;

endmodule

// File: rtl/farm_request_gen.sv
// rtl/farm_request_gen.sv - farm-road car queue, request FSM and light protocol checker
module farm_request_gen
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int SERVE_CYCLES    = 3,
  parameter int MAX_WAIT        = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic [2:0]       light_highway,
  input  logic [2:0]       light_farm,
  output logic             req,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             sat,
  output logic             starved,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int TW = $clog2(SERVE_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic             arrival, departure, farm_green;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             perr_q, perr_d;
  req_state_e       state_q, state_d;

  tlc_sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (loop_raw),
    .arrival_o (arrival)
  );

  assign farm_green = (light_farm == LIGHT_GRN);
  assign departure  = farm_green && (cnt_q != '0) && (tmr_q == TW'(SERVE_CYCLES - 1));

  // Service timer: one departure every SERVE_CYCLES green cycles while cars are waiting.
  always_comb begin
    tmr_d = tmr_q;
    if (!farm_green) begin
      tmr_d = '0;
    end else if (cnt_q != '0) begin
      tmr_d = departure ? '0 : tmr_q + 1'b1;
    end
  end

  // Queue count with saturation; sat is sticky until the queue drains.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (arrival && !departure) begin
      if (cnt_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (departure && !arrival) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (cnt_d == '0) begin
      sat_d = 1'b0;
    end
  end

  // Request FSM: raise C while cars wait, drop it for the farm green, track how long we wait.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (cnt_d != '0) begin
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (farm_green) begin
          state_d = SERVING;
          wait_d  = '0;
        end else if (wait_q != WW'(MAX_WAIT)) begin
          wait_d = wait_q + 1'b1;
        end
      end
      SERVING: begin
        wait_d = '0;
        if (!farm_green) begin
          state_d = (cnt_d != '0) ? REQUEST : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Sticky protocol error on an illegal code or on both roads showing non-red.
  always_comb begin
    perr_d = perr_q;
    if (!light_legal(light_highway) || !light_legal(light_farm) ||
        ((light_highway != LIGHT_RED) && (light_farm != LIGHT_RED))) begin
      perr_d = 1'b1;
    end
  end

  // State registers; reset discards the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      wait_q  <= '0;
      perr_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      wait_q  <= wait_d;
      perr_q  <= perr_d;
      state_q <= state_d;
    end
  end

  assign req       = (state_q == REQUEST);
  assign starved   = (state_q == REQUEST) && (wait_q == WW'(MAX_WAIT));
  assign queue_cnt = cnt_q;
  assign sat       = sat_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_farm_request_gen.sv
// tb/tb_farm_request_gen.sv - self-checking bench for farm_request_gen
module tb_farm_request_gen;

  localparam int D     = 4;
  localparam int SERVE = 3;
  localparam int MAXW  = 15;
  localparam int QMAX  = 15;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk;
  logic       rst;
  logic       loop_raw;
  logic [2:0] light_highway;
  logic [2:0] light_farm;
  logic       req;
  logic [3:0] queue_cnt;
  logic       sat;
  logic       starved;
  logic       proto_err;

  int n_cmp;
  int n_bad;
  bit chk_en;

  // reference state
  bit d1, d2, m_deb, m_pend, m_sat, m_perr;
  int m_run, m_q, m_gcnt, m_mode, m_reqcyc;

  farm_request_gen dut (
    .clk           (clk),
    .rst           (rst),
    .loop_raw      (loop_raw),
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .req           (req),
    .queue_cnt     (queue_cnt),
    .sat           (sat),
    .starved       (starved),
    .proto_err     (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = requesting, 2 = farm being served.
  always @(posedge clk or posedge rst) begin : mdl
    bit s, arr, arr_now, dep, green;
    int qn;
    if (rst) begin
      d1 = 0; d2 = 0; m_deb = 0; m_run = 0; m_pend = 0;
      m_q = 0; m_sat = 0; m_gcnt = 0; m_mode = 0; m_reqcyc = 0; m_perr = 0;
    end else begin
      green = (light_farm == GRN);
      arr   = m_pend;
      dep   = 0;
      if (!green) m_gcnt = 0;
      else if (m_q > 0) begin
        m_gcnt++;
        if (m_gcnt % SERVE == 0) dep = 1;
      end
      qn = m_q;
      if (arr && !dep) begin
        if (m_q == QMAX) m_sat = 1;
        else qn = m_q + 1;
      end else if (dep && !arr) begin
        qn = m_q - 1;
      end
      m_q = qn;
      if (m_q == 0) m_sat = 0;

      if (m_mode == 0) begin
        if (qn > 0) begin m_mode = 1; m_reqcyc = 0; end
      end else if (m_mode == 1) begin
        if (green) begin m_mode = 2; m_reqcyc = 0; end
        else m_reqcyc++;
      end else begin
        if (!green) m_mode = (qn > 0) ? 1 : 0;
      end

      if ($countones(light_highway) != 1 || $countones(light_farm) != 1 ||
          (light_highway != RED && light_farm != RED)) m_perr = 1;

      s = d2; d2 = d1; d1 = loop_raw;
      arr_now = 0;
      if (s != m_deb) m_run++;
      else m_run = 0;
      if (m_run == D) begin
        m_deb = s; m_run = 0; arr_now = s;
      end
      m_pend = arr_now;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("req", req, (m_mode == 1) ? 1 : 0);
      check("queue_cnt", queue_cnt, m_q);
      check("sat", sat, m_sat);
      check("starved", starved, (m_mode == 1 && m_reqcyc >= MAXW) ? 1 : 0);
      check("proto_err", proto_err, m_perr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic car();
    loop_raw = 1'b1;
    tick(10);
    loop_raw = 1'b0;
    tick(8);
  endtask

  task automatic lights(input logic [2:0] h, input logic [2:0] f);
    light_highway = h;
    light_farm    = f;
  endtask

  task automatic to_farm_green();
    lights(YEL, RED); tick(1);
    lights(RED, RED); tick(1);
    lights(RED, GRN);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0;
    rst = 1'b1; loop_raw = 1'b0;
    lights(GRN, RED);
    tick(3);
    rst = 1'b0;
    check("rst_req", req, 0);
    check("rst_queue", queue_cnt, 0);
    check("rst_sat", sat, 0);
    check("rst_starved", starved, 0);
    check("rst_perr", proto_err, 0);
    chk_en = 1;
    tick(50);

    // arrival latency
    loop_raw = 1'b1;
    tick(6);
    check("lat_q_early", queue_cnt, 0);
    check("lat_req_early", req, 0);
    tick(1);
    check("lat_q", queue_cnt, 1);
    check("lat_req", req, 1);
    tick(3);
    loop_raw = 1'b0;
    tick(8);

    // short glitch is rejected
    loop_raw = 1'b1; tick(3);
    loop_raw = 1'b0; tick(10);
    check("glitch_q", queue_cnt, 1);

    // three cars served by a 9-cycle green
    car(); car();
    check("three_q", queue_cnt, 3);
    to_farm_green();
    tick(1); check("serve_req_drop", req, 0);
    tick(1); check("serve_q_g2", queue_cnt, 3);
    tick(1); check("serve_q_g3", queue_cnt, 2);
    tick(3); check("serve_q_g6", queue_cnt, 1);
    tick(3); check("serve_q_g9", queue_cnt, 0);
    lights(RED, RED); tick(1);
    check("serve_idle_req", req, 0);
    lights(GRN, RED); tick(2);

    // two cars, one departure, back to request
    car(); car();
    check("two_q", queue_cnt, 2);
    to_farm_green();
    tick(3); check("part_q", queue_cnt, 1);
    lights(RED, RED); tick(1);
    check("part_req", req, 1);

    // arrival coinciding with a departure
    loop_raw = 1'b1; tick(4);
    lights(RED, GRN);
    tick(2); check("coin_q_before", queue_cnt, 1);
    tick(1); check("coin_q_same", queue_cnt, 1);
    tick(3); check("coin_q_after", queue_cnt, 0);
    loop_raw = 1'b0;
    lights(RED, RED); tick(1);
    check("coin_idle_req", req, 0);
    tick(8);
    lights(GRN, RED); tick(2);

    // starvation
    loop_raw = 1'b1; tick(7);
    check("starve_req", req, 1);
    tick(3); loop_raw = 1'b0;
    tick(11); check("starve_14", starved, 0);
    tick(1);  check("starve_15", starved, 1);
    tick(5);
    to_farm_green();
    tick(1);
    check("starve_clear", starved, 0);
    check("starve_serving_req", req, 0);
    tick(2); check("starve_q0", queue_cnt, 0);
    lights(RED, RED); tick(1);
    lights(GRN, RED); tick(2);

    // saturation
    repeat (15) car();
    check("sat15_q", queue_cnt, 15);
    check("sat15_flag", sat, 0);
    car();
    check("sat16_q", queue_cnt, 15);
    check("sat16_flag", sat, 1);

    // reset mid-queue clears outputs immediately
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("mid_rst_q", queue_cnt, 0);
    check("mid_rst_req", req, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_starved", starved, 0);
    check("mid_rst_perr", proto_err, 0);
    tick(2);
    rst = 1'b0;
    tick(3);

    // protocol checker
    check("perr_clean", proto_err, 0);
    lights(GRN, GRN); tick(1);
    check("perr_both_green", proto_err, 1);
    lights(GRN, 3'b011); tick(1);
    lights(GRN, RED); tick(3);
    check("perr_sticky", proto_err, 1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("perr_rst", proto_err, 0);
    tick(2);
    check("perr_after_rst", proto_err, 0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/farm_request_gen.md
Name: farm_request_gen

Overview:
Sensor-side counterpart of the highway/farm traffic-light controller. Conditions the raw farm-road loop detector and keeps a count of waiting cars. Drives the controller's car-present request (C) and withdraws it once the farm road is green and its queue is served. It monitors the controller's returned light codes and flags protocol violations. It sits between the pad-level loop detector and the controller's C input.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed before the debounced level changes (>=1)
CNT_W, 4, width of the waiting-car counter
SERVE_CYCLES, 3, farm-green cycles per departing car (>=1)
MAX_WAIT, 15, request cycles before starved asserts

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
loop_raw  input  1  raw loop detector, asynchronous to clk, 1 = car over loop
light_highway  input  3  controller highway lights: 100 red, 010 yellow, 001 green
light_farm  input  3  controller farm lights, same encoding
req  output  1  car-present request to the controller's C input
queue_cnt  output  CNT_W  cars currently waiting
sat  output  1  sticky: an arrival occurred with queue_cnt at maximum
starved  output  1  request pending for MAX_WAIT or more cycles
proto_err  output  1  sticky light-protocol violation

Behaviour:
- Reset (async, rst=1): req=0, queue_cnt=0, sat=0, starved=0, proto_err=0, FSM=IDLE, synchronizer/debounce/timers cleared (debounced level 0). Reset mid-operation discards the queue immediately.
- Input path: 2-flop synchronizer, then debounce counter. The counter counts consecutive cycles where the synced value differs from the debounced level and clears on any agreeing sample. The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
- Arrival: one-cycle pulse on the debounced 0->1 edge. Departures of cars are not sensed.
- End-to-end latency: loop_raw rising before edge k gives queue_cnt increment and req=1 visible after edge k+DEBOUNCE_CYCLES+2 (7 cycles for default). Glitches shorter than DEBOUNCE_CYCLES cycles after synchronization produce no arrival.
- Service timer: cleared whenever light_farm!=001. While light_farm==001 and queue_cnt>0 it counts. On reaching SERVE_CYCLES-1 it emits a departure and wraps to 0.
- Queue update, per cycle:
  - arrival only: +1, saturating at 2^CNT_W-1; arrival at max sets sat.
  - departure only: -1; never below 0.
  - arrival and departure together: count unchanged.
  - sat clears only when queue_cnt reaches 0 or on reset.
- FSM (registered outputs):
  - IDLE: req=0. Goes to REQUEST when queue_cnt>0 (including the cycle after an arrival).
  - REQUEST: req=1, wait counter increments each cycle, saturating at MAX_WAIT; starved=1 when the wait counter equals MAX_WAIT. Goes to SERVING when light_farm==001.
  - SERVING: req=0, wait counter cleared, starved=0. When light_farm leaves 001: to REQUEST if queue_cnt>0, else IDLE. Arrivals during SERVING are counted but raise no request until green ends.
- req is held steady while in REQUEST regardless of controller state, because the controller samples C only in highway-green.
- Protocol checker: proto_err sets (sticky until reset) in any cycle where:
  - either light code is not exactly one of 100/010/001, or
  - neither light equals 100 (both roads non-red).
  The checker is active from the first cycle after reset release. The FSM ignores proto_err.

Decomposition:
- Shared package tlc_pkg:
  - light codes LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001
  - request FSM state enum (IDLE, REQUEST, SERVING), 2 bits
  - used by this block and the controller.
- One sub-module: tlc_sensor_debounce (synchronizer + debounce counter + arrival pulse, parameter DEBOUNCE_CYCLES).
- Queue, service timer, FSM and protocol checker stay in farm_request_gen.

Test Plan:
- Reset then idle, lights hwy=001 farm=100: req=0, queue_cnt=0, all flags 0 for 50 cycles; assert rst mid-queue (queue_cnt=3) -> all outputs 0 immediately.
- loop_raw high 10 cycles (defaults): req=1 and queue_cnt=1 exactly 7 cycles after the rise. A 3-cycle loop_raw glitch -> no change.
- Three arrivals, then drive farm=001 for 9 cycles: req drops the cycle after farm=001. queue_cnt steps 3->2->1->0 at every 3rd green cycle. Farm=100 then -> IDLE, req=0.
- Two arrivals, farm green for 3 cycles only (one departure), then red: queue_cnt=1, FSM returns to REQUEST, req=1. Arrival coinciding with a departure -> queue_cnt unchanged.
- Hold REQUEST with lights never green for 20 cycles: starved=1 from the 15th wait cycle, cleared on entering SERVING. 16 arrivals with CNT_W=4 -> queue_cnt=15, sat=1.
- Drive hwy=001 with farm=001, then farm=011: proto_err=1 after the first violating cycle, stays 1 after legal codes resume, clears only on rst.
